// File: rtl/motion_scheduler.sv
// Per-frame motion sequencer: gates vsync rising edges with pause/step control and
// runs a two-phase (X then Y) bouncing Q10.4 position update, flagging frame overruns.
module motion_scheduler #(
  parameter int X_LIMIT  = 600,
  parameter int Y_LIMIT  = 440,
  parameter int X_INIT_Q = 0,
  parameter int Y_INIT_Q = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        vsync,
  input  logic        paused,
  input  logic [11:0] step_size,
  input  logic        step_req,
  output logic [9:0]  pos_x,
  output logic [9:0]  pos_y,
  output logic        dir_x,
  output logic        dir_y,
  output logic [7:0]  frame_cnt,
  output logic        update_done,
  output logic        overrun
);

  localparam logic [14:0] X_BOUND = 15'(X_LIMIT * 16);
  localparam logic [14:0] Y_BOUND = 15'(Y_LIMIT * 16);
  localparam logic [13:0] X_INIT  = 14'(X_INIT_Q);
  localparam logic [13:0] Y_INIT  = 14'(Y_INIT_Q);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    UPD_X = 2'd1,
    UPD_Y = 2'd2
  } state_t;

  typedef struct packed {
    logic [13:0] acc;
    logic        dir;
  } axis_t;

  state_t      state, next_state;
  logic [13:0] acc_x, acc_y;
  logic [11:0] step_q;
  logic        vsync_d;
  logic        step_pending;
  logic        vs_rise;
  logic        advance;
  axis_t       next_x, next_y;

  // One move along an axis with a single reflection at either end of [0, bound].
  function automatic axis_t bounce(input logic [13:0] acc, input logic dir,
                                   input logic [13:0] s, input logic [14:0] bound);
    axis_t       r;
    logic [14:0] n;
    r.acc = acc;
    r.dir = dir;
    n     = {1'b0, acc} + {1'b0, s};
    if (dir) begin
      if (n >= bound) begin
        r.acc = 14'((bound << 1) - n);
        r.dir = 1'b0;
      end else begin
        r.acc = n[13:0];
      end
    end else begin
      if (s >= acc) begin
        r.acc = s - acc;
        r.dir = 1'b1;
      end else begin
        r.acc = acc - s;
      end
    end
    return r;
  endfunction

  assign vs_rise = vsync & ~vsync_d;
  assign advance = vs_rise & (~paused | step_pending) & (state == IDLE);

  assign next_x = bounce(acc_x, dir_x, {2'b00, step_q}, X_BOUND);
  assign next_y = bounce(acc_y, dir_y, {2'b00, step_q}, Y_BOUND);

  assign pos_x = acc_x[13:4];
  assign pos_y = acc_y[13:4];

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values, independent of statement order inside the block.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // NOTE: next_state gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (advance) next_state = UPD_X;
      UPD_X:   next_state = UPD_Y;
      UPD_Y:   next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_x        <= X_INIT;
      acc_y        <= Y_INIT;
      dir_x        <= 1'b1;
      dir_y        <= 1'b1;
      step_q       <= '0;
      vsync_d      <= 1'b0;
      step_pending <= 1'b0;
      frame_cnt    <= '0;
      update_done  <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      vsync_d     <= vsync;
      update_done <= (state == UPD_Y);

      // A request arriving alongside the advance it would have enabled is consumed by it.
      if (advance) begin
        step_pending <= 1'b0;
      end else if (step_req && paused) begin
        step_pending <= 1'b1;
      end

      if (advance) begin
        step_q    <= step_size;
        frame_cnt <= frame_cnt + 8'd1;
      end

      if (vs_rise && state != IDLE) begin
        overrun <= 1'b1;
      end

      if (state == UPD_X) begin
        acc_x <= next_x.acc;
        dir_x <= next_x.dir;
      end

      if (state == UPD_Y) begin
        acc_y <= next_y.acc;
        dir_y <= next_y.dir;
      end
    end
  end

endmodule

// File: tb/tb_motion_scheduler.sv
// Scoreboard bench for motion_scheduler: a frame-level reference model predicts each
// committed update; a monitor checks it when update_done pulses.
module tb_motion_scheduler;

  localparam int XL = 600;
  localparam int YL = 3;
  localparam int XI = 9584;
  localparam int YI = 0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        vsync = 1'b0;
  logic        paused = 1'b0;
  logic [11:0] step_size = '0;
  logic        step_req = 1'b0;
  logic [9:0]  pos_x, pos_y;
  logic        dir_x, dir_y;
  logic [7:0]  frame_cnt;
  logic        update_done, overrun;

  motion_scheduler #(
    .X_LIMIT (XL),
    .Y_LIMIT (YL),
    .X_INIT_Q(XI),
    .Y_INIT_Q(YI)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .vsync      (vsync),
    .paused     (paused),
    .step_size  (step_size),
    .step_req   (step_req),
    .pos_x      (pos_x),
    .pos_y      (pos_y),
    .dir_x      (dir_x),
    .dir_y      (dir_y),
    .frame_cnt  (frame_cnt),
    .update_done(update_done),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int ax;
    int ay;
    bit dx;
    bit dy;
    int fc;
    int at;
  } exp_t;

  exp_t sb[$];

  // Reference model state, in whole Q10.4 integers.
  int m_ax, m_ay, m_fc, m_busy;
  bit m_dx, m_dy, m_pend, m_ovr, m_vd;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void move(inout int a, inout bit d, input int s, input int lim);
    if (d) begin
      if (a + s >= lim) begin
        a = 2 * lim - (a + s);
        d = 1'b0;
      end else begin
        a = a + s;
      end
    end else begin
      if (s >= a) begin
        a = s - a;
        d = 1'b1;
      end else begin
        a = a - s;
      end
    end
  endfunction

  function automatic void model_reset();
    m_ax = XI; m_ay = YI; m_dx = 1'b1; m_dy = 1'b1;
    m_fc = 0; m_busy = 0; m_pend = 1'b0; m_ovr = 1'b0; m_vd = 1'b0;
  endfunction

  // Predicts what the coming clock edge does; an advance keeps the block busy for two cycles.
  task automatic model(input bit v, input bit p, input bit sr, input int s);
    bit   rise, idle, adv;
    exp_t e;
    rise = v && !m_vd;
    idle = (m_busy == 0);
    adv  = rise && idle && (!p || m_pend);
    if (rise && !idle) m_ovr = 1'b1;
    if (adv) begin
      m_pend = 1'b0;
      move(m_ax, m_dx, s, XL * 16);
      move(m_ay, m_dy, s, YL * 16);
      m_fc = (m_fc + 1) % 256;
      e.ax = m_ax; e.ay = m_ay; e.dx = m_dx; e.dy = m_dy; e.fc = m_fc; e.at = cyc + 3;
      sb.push_back(e);
      m_busy = 2;
    end else begin
      if (m_busy > 0) m_busy--;
      if (sr && p) m_pend = 1'b1;
    end
    m_vd = v;
  endtask

  task automatic tick(input bit v, input bit p, input bit sr, input int s);
    vsync = v; paused = p; step_req = sr; step_size = 12'(s);
    model(v, p, sr, s);
    @(posedge clk);
    #1;
  endtask

  task automatic frame(input bit p, input int s, input int gap);
    tick(1'b1, p, 1'b0, s);
    repeat (gap) tick(1'b0, p, 1'b0, s);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_pos_x"}, 32'(pos_x), XI / 16);
    check({tag, "_pos_y"}, 32'(pos_y), YI / 16);
    check({tag, "_dir_x"}, 32'(dir_x), 1);
    check({tag, "_dir_y"}, 32'(dir_y), 1);
    check({tag, "_frame_cnt"}, 32'(frame_cnt), 0);
    check({tag, "_update_done"}, 32'(update_done), 0);
    check({tag, "_overrun"}, 32'(overrun), 0);
  endtask

  // Monitor: every update_done pulse must match the oldest predicted update.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && update_done) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL spurious_update_done: got pulse expected none (t=%0t)", $time);
      end else begin
        e = sb.pop_front();
        check("done_cycle", 32'(cyc), 32'(e.at));
        check("pos_x", 32'(pos_x), 32'(e.ax / 16));
        check("pos_y", 32'(pos_y), 32'(e.ay / 16));
        check("dir_x", 32'(dir_x), 32'(e.dx));
        check("dir_y", 32'(dir_y), 32'(e.dy));
        check("frame_cnt", 32'(frame_cnt), 32'(e.fc));
      end
    end
  end

  initial begin
    model_reset();
    #12;
    check_reset_outputs("reset");
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Free run at one pixel per frame: X hits its limit exactly on the first frame.
    repeat (3) frame(1'b0, 16, 4);
    // Fractional steps of 1/8 pixel.
    repeat (8) frame(1'b0, 2, 4);

    // Paused: edges are ignored entirely.
    repeat (5) frame(1'b1, 16, 4);
    check("paused_frame_cnt", 32'(frame_cnt), 32'(m_fc));
    // One step request buys exactly one frame.
    tick(1'b0, 1'b1, 1'b1, 24);
    repeat (2) frame(1'b1, 24, 4);
    check("step_frame_cnt", 32'(frame_cnt), 32'(m_fc));
    // Request coinciding with an edge only arms the next edge.
    tick(1'b1, 1'b1, 1'b1, 24);
    repeat (4) tick(1'b0, 1'b1, 1'b0, 24);
    repeat (2) frame(1'b1, 24, 4);

    // Overrun: second edge lands during UPD_Y and is dropped.
    check("overrun_before", 32'(overrun), 32'(m_ovr));
    tick(1'b1, 1'b0, 1'b0, 16);
    tick(1'b0, 1'b0, 1'b0, 16);
    tick(1'b1, 1'b0, 1'b0, 16);
    repeat (4) tick(1'b0, 1'b0, 1'b0, 16);
    check("overrun_after", 32'(overrun), 32'(m_ovr));
    check("overrun_frame_cnt", 32'(frame_cnt), 32'(m_fc));

    // Randomised frames with pause, step requests and step_size churn every cycle.
    for (int f = 0; f < 300; f++) begin
      bit p;
      int hi, lo;
      p  = ($urandom_range(0, 4) == 0);
      hi = $urandom_range(1, 2);
      lo = $urandom_range(1, 5);
      for (int i = 0; i < hi; i++) tick(1'b1, p, ($urandom_range(0, 9) == 0), $urandom_range(0, 48));
      for (int i = 0; i < lo; i++) tick(1'b0, p, ($urandom_range(0, 9) == 0), $urandom_range(0, 48));
    end
    repeat (6) tick(1'b0, 1'b0, 1'b0, 0);
    check("scoreboard_drained", 32'(sb.size()), 0);
    check("random_overrun", 32'(overrun), 32'(m_ovr));
    check("random_frame_cnt", 32'(frame_cnt), 32'(m_fc));
    check("random_pos_x", 32'(pos_x), 32'(m_ax / 16));
    check("random_pos_y", 32'(pos_y), 32'(m_ay / 16));

    // Reset in the middle of an update: outputs must drop before the next edge.
    tick(1'b1, 1'b0, 1'b0, 24);
    #2;
    vsync = 1'b0;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    sb.delete();
    model_reset();
    #4 rst_n = 1'b1;
    @(posedge clk);
    #1;
    repeat (3) frame(1'b0, 16, 4);
    check("post_reset_frame_cnt", 32'(frame_cnt), 32'(m_fc));
    check("post_reset_drained", 32'(sb.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/motion_scheduler.md
Name: motion_scheduler

Overview:
Per-frame motion sequencer for the pattern generator. It detects the vsync rising edge and gates it with the speed controller's `paused` flag. It then sequences a two-phase (X then Y) update of a bouncing Q10.4 position accumulator by `step_size`. It also supports single-frame stepping while paused and reports frame overruns.

Parameters:
- X_LIMIT, 600, horizontal travel limit in whole pixels; the Q10.4 bound is X_LIMIT*16.
- Y_LIMIT, 440, vertical travel limit in whole pixels; the Q10.4 bound is Y_LIMIT*16.
- X_INIT_Q, 0, reset value of the X accumulator in Q10.4 units (must be ≤ X_LIMIT*16).
- Y_INIT_Q, 0, reset value of the Y accumulator in Q10.4 units (must be ≤ Y_LIMIT*16).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- vsync  in  1  vsync from the VGA timing generator, synchronous to clk, active-high
- paused  in  1  pause state from the speed controller
- step_size  in  12  Q8.4 increment per frame from the speed controller
- step_req  in  1  one-cycle request to advance exactly one frame while paused
- pos_x  out  10  integer part of the X accumulator
- pos_y  out  10  integer part of the Y accumulator
- dir_x  out  1  1 = moving +X, 0 = moving −X
- dir_y  out  1  1 = moving +Y, 0 = moving −Y
- frame_cnt  out  8  count of advanced frames, wraps 255→0
- update_done  out  1  one-cycle pulse when the Y phase commits
- overrun  out  1  sticky flag: a vsync edge arrived while an update was in progress

Behaviour:
- Reset (rst_n=0, asynchronous):
  - accumulators load X_INIT_Q / Y_INIT_Q; dir_x = dir_y = 1
  - frame_cnt = 0, update_done = 0, overrun = 0
  - step_pending = 0, vsync_d = 0, state = IDLE
- Edge detection: vsync_d registers vsync; vs_rise = vsync & ~vsync_d. This is combinational, with no extra cycle.
- Step request: step_req sets step_pending when paused = 1; it is ignored when paused = 0. step_pending clears when an advance starts.
- Advance start: advance = vs_rise & (~paused | step_pending), taken only in IDLE.
  - On advance, step_size is captured into step_q and the FSM moves IDLE→UPD_X.
  - frame_cnt increments on the same edge.
- FSM: IDLE → UPD_X → UPD_Y → IDLE, one cycle per state.
  - pos_x is visible the cycle after UPD_X; pos_y the cycle after UPD_Y.
  - update_done is high for the single cycle following UPD_Y, i.e. 3 clocks after the vs_rise cycle.
- Per-axis arithmetic (A = 14-bit accumulator, L = LIMIT*16, s = step_q zero-extended to 14 bits; compute in 15 bits, no overflow allowed):
  - dir = 1: n = A + s. If n ≥ L then A ← 2L − n and dir ← 0; else A ← n. Hitting the limit exactly gives A = L and flips dir.
  - dir = 0: if s ≥ A then A ← s − A and dir ← 1; else A ← A − s. Hitting 0 exactly gives A = 0 and flips dir.
  - step_size ≤ L is guaranteed by the speed-controller range (max 24). Only a single reflection is performed.
- Outputs: pos_x = A_x[13:4], pos_y = A_y[13:4]. All outputs are registered.
- vs_rise while state ≠ IDLE: the edge is dropped, overrun ← 1 (held until reset), and the current update completes unaffected.
- paused rising mid-update: the in-flight update completes; pausing takes effect at the next vs_rise.
- step_req and vs_rise in the same cycle while paused, with step_pending = 0: no advance this frame; step_pending is set for the next edge.
- step_size changing mid-update: no effect, because step_q is latched at start.
- Reset asserted mid-update: immediately returns to reset values; no partial commit survives.

Test Plan:
- Free-run: reset, paused = 0, step_size = 16, 3 vsync pulses → pos_x = pos_y = 3, frame_cnt = 3, three update_done pulses, each 3 clocks after its vs_rise.
- Fractional step: step_size = 2, 8 vsync pulses → A_x = 16, pos_x = 1; after 7 pulses pos_x = 0.
- +X bounce: X_INIT_Q = 9592, step_size = 16 → n = 9608, A_x = 9592, dir_x = 0. Exact hit: X_INIT_Q = 9584 → A_x = 9600, dir_x = 0.
- −Y bounce: drive 3 frames to A_y = 48, force the −Y direction by a prior bounce with Y_LIMIT = 3 (L = 48). Next step 24 → A_y = 24, dir_y = 0. Then a step of 24 → A_y = 0, dir_y = 1.
- Pause/step: paused = 1, 5 vsync pulses → positions and frame_cnt unchanged. One step_req followed by 2 vsync pulses → exactly one advance, frame_cnt + 1.
- Overrun and reset: two vs_rise edges 1 clock apart → second edge ignored, overrun = 1, frame_cnt + 1 only. Pull rst_n low during UPD_X → all outputs return to reset values asynchronously.
